cory_pipe: RTL and testbench

CORY_PIPE -- requirements
Module: cory_pipe

---
 rtl/cory_pipe.sv | 93 +++++++++
 tb/tb_cory_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cory_pipe.sv
// Elastic valid/ready pipeline of D stages with bubble collapse, flush and occupancy count.
// D=0 degenerates to a combinational passthrough.
module cory_pipe #(
  parameter int unsigned N  = 8,
  parameter int unsigned D  = 4,
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_a_valid,
  input  logic [N-1:0]  i_a,
  output logic          o_a_ready,
  output logic          o_z_valid,
  output logic [N-1:0]  o_z,
  input  logic          i_z_ready,
  input  logic          i_flush,
  output logic [CW-1:0] o_cnt
);

  generate
    if (D == 0) begin : g_pass
      // No state: clock and reset are intentionally unused here.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset_n;

      assign o_z       = i_a;
      assign o_z_valid = i_a_valid & ~i_flush;
      assign o_a_ready = i_z_ready & ~i_flush;
      assign o_cnt     = '0;
    end else begin : g_pipe
      logic [D-1:0]  v_q;
      logic [D-1:0]  v_d;
      logic [D-1:0]  v_in;
      logic [D-1:0]  en;
      logic [N-1:0]  data_q [D];
      logic [N-1:0]  d_in   [D];
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      // Stage enables ripple back from the output so empty stages absorb stalls.
      always_comb begin
        en       = '0;
        en[D-1]  = ~v_q[D-1] | i_z_ready;
        for (int k = int'(D) - 2; k >= 0; k--) begin
          en[k] = ~v_q[k] | en[k+1];
        end
      end

      // Incoming valid per stage: i_a_valid feeds stage 0, stage k-1 feeds stage k.
      assign v_in = D'({v_q, i_a_valid});

      always_comb begin
        d_in[0] = i_a;
        for (int k = 1; k < int'(D); k++) begin
          d_in[k] = data_q[k-1];
        end
      end

      // Next valid bits and the occupancy they imply, registered alongside v_q.
      always_comb begin
        v_d   = i_flush ? '0 : ((en & v_in) | (~en & v_q));
        cnt_d = '0;
        for (int k = 0; k < int'(D); k++) begin
          cnt_d = cnt_d + CW'(v_d[k]);
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          v_q   <= '0;
          cnt_q <= '0;
          for (int k = 0; k < int'(D); k++) begin
            data_q[k] <= '0;
          end
        end else begin
          v_q   <= v_d;
          cnt_q <= cnt_d;
          for (int k = 0; k < int'(D); k++) begin
            if (en[k] && v_in[k]) begin
              data_q[k] <= d_in[k];
            end
          end
        end
      end

      assign o_a_ready = en[0] & ~i_flush;
      assign o_z_valid = v_q[D-1] & ~i_flush;
      assign o_z       = data_q[D-1];
      assign o_cnt     = cnt_q;
    end
  endgenerate

endmodule

// File: tb/tb_cory_pipe.sv
// Directed bench for cory_pipe: a D=4 pipe and a D=0 passthrough instance.
module tb_cory_pipe;
  localparam int unsigned N  = 8;
  localparam int unsigned CW = 3;

  logic          clk;
  logic          reset_n;
  logic          a_valid, a_ready, z_valid, z_ready, flush;
  logic [N-1:0]  a, z;
  logic [CW-1:0] cnt;

  logic          p_a_valid, p_a_ready, p_z_valid, p_z_ready, p_flush;
  logic [N-1:0]  p_a, p_z;
  logic [CW-1:0] p_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  cory_pipe #(.N(N), .D(4), .CW(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_a_valid(a_valid), .i_a(a), .o_a_ready(a_ready),
    .o_z_valid(z_valid), .o_z(z), .i_z_ready(z_ready),
    .i_flush(flush), .o_cnt(cnt)
  );

  cory_pipe #(.N(N), .D(0), .CW(CW)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .i_a_valid(p_a_valid), .i_a(p_a), .o_a_ready(p_a_ready),
    .o_z_valid(p_z_valid), .o_z(p_z), .i_z_ready(p_z_ready),
    .i_flush(p_flush), .o_cnt(p_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_tests++; if (z_valid !== 1'b0) begin n_fail++; $display("FAIL reset_z_valid got %b want 0", z_valid); end
    n_tests++; if (z !== 8'h00) begin n_fail++; $display("FAIL reset_z got %h want 00", z); end
    n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL reset_a_ready got %b want 1", a_ready); end
    n_tests++; if (cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", cnt); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // 0x01..0x08 back to back; output appears 4 cycles after each accept.
  task automatic test_stream();
    logic [CW-1:0] exp_cnt;
    z_ready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      a_valid = (c < 8);
      a       = 8'(c + 1);
      #1;
      exp_cnt = (c <= 8) ? CW'((c < 4) ? c : 4) : CW'(12 - c);
      n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready c=%0d got %b want 1", c, a_ready); end
      n_tests++; if (z_valid !== (c >= 4 && c < 12)) begin n_fail++; $display("FAIL stream_valid c=%0d got %b want %b", c, z_valid, (c >= 4 && c < 12)); end
      if (c >= 4 && c < 12) begin
        n_tests++; if (z !== 8'(c - 3)) begin n_fail++; $display("FAIL stream_data c=%0d got %h want %h", c, z, 8'(c - 3)); end
      end
      n_tests++; if (cnt !== exp_cnt) begin n_fail++; $display("FAIL stream_cnt c=%0d got %0d want %0d", c, cnt, exp_cnt); end
      tick();
    end
    a_valid = 1'b0;
  endtask

  // Fill with output stalled, check full behaviour, then drain in order.
  task automatic test_stall();
    logic [7:0] exp_z [7];
    logic       exp_v [7];
    exp_z = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'h00};
    exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    z_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      a_valid = 1'b1;
      a       = 8'(8'hA0 + c);
      #1;
      n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL stall_fill_ready c=%0d got %b want 1", c, a_ready); end
      tick();
    end
    a = 8'hA4;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL stall_full_ready got %b want 0", a_ready); end
      n_tests++; if (cnt !== 3'd4) begin n_fail++; $display("FAIL stall_full_cnt got %0d want 4", cnt); end
      n_tests++; if (z_valid !== 1'b1 || z !== 8'hA0) begin n_fail++; $display("FAIL stall_hold got v=%b z=%h want v=1 z=a0", z_valid, z); end
      tick();
    end
    z_ready = 1'b1;
    for (int r = 0; r < 7; r++) begin
      a_valid = (r < 2);
      a       = (r == 0) ? 8'hA4 : 8'hA5;
      #1;
      if (r == 0) begin
        n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL stall_full_passthru_ready got %b want 1", a_ready); end
      end
      n_tests++; if (z_valid !== exp_v[r]) begin n_fail++; $display("FAIL stall_drain_valid r=%0d got %b want %b", r, z_valid, exp_v[r]); end
      if (exp_v[r]) begin
        n_tests++; if (z !== exp_z[r]) begin n_fail++; $display("FAIL stall_drain_data r=%0d got %h want %h", r, z, exp_z[r]); end
      end
      tick();
    end
    a_valid = 1'b0;
  endtask

  // Gap between two words closes up behind a stalled output.
  task automatic test_bubble();
    z_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      a_valid = (c == 0 || c == 3);
      a       = (c == 0) ? 8'h55 : 8'h66;
      #1;
      if (c == 3) begin
        n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL bubble_ready got %b want 1", a_ready); end
      end
      if (c == 6) begin
        n_tests++; if (cnt !== 3'd2) begin n_fail++; $display("FAIL bubble_cnt got %0d want 2", cnt); end
        n_tests++; if (z_valid !== 1'b1 || z !== 8'h55) begin n_fail++; $display("FAIL bubble_head got v=%b z=%h want v=1 z=55", z_valid, z); end
      end
      tick();
    end
    a_valid = 1'b0;
    z_ready = 1'b1;
    #1;
    n_tests++; if (z_valid !== 1'b1 || z !== 8'h55 || cnt !== 3'd2) begin n_fail++; $display("FAIL bubble_out0 got v=%b z=%h cnt=%0d want v=1 z=55 cnt=2", z_valid, z, cnt); end
    tick();
    #1;
    n_tests++; if (z_valid !== 1'b1 || z !== 8'h66 || cnt !== 3'd1) begin n_fail++; $display("FAIL bubble_out1 got v=%b z=%h cnt=%0d want v=1 z=66 cnt=1", z_valid, z, cnt); end
    tick();
    #1;
    n_tests++; if (z_valid !== 1'b0 || cnt !== 3'd0) begin n_fail++; $display("FAIL bubble_empty got v=%b cnt=%0d want v=0 cnt=0", z_valid, cnt); end
    tick();
  endtask

  // Flush with three words held and a live input word that must be dropped.
  task automatic test_flush();
    z_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      a_valid = 1'b1;
      a       = 8'(8'h31 + c);
      tick();
    end
    a_valid = 1'b1;
    a       = 8'h77;
    flush   = 1'b1;
    #1;
    n_tests++; if (cnt !== 3'd3) begin n_fail++; $display("FAIL flush_pre_cnt got %0d want 3", cnt); end
    n_tests++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready_during got %b want 0", a_ready); end
    tick();
    flush   = 1'b0;
    a_valid = 1'b0;
    #1;
    n_tests++; if (cnt !== 3'd0) begin n_fail++; $display("FAIL flush_cnt got %0d want 0", cnt); end
    n_tests++; if (z_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", z_valid); end
    n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready_after got %b want 1", a_ready); end
    z_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_tests++; if (z_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak c=%0d got v=%b z=%h want v=0", c, z_valid, z); end
    end
    tick();
  endtask

  // Asynchronous reset mid-cycle, then a fresh word with full latency.
  task automatic test_reset_mid();
    z_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      a_valid = (c < 2);
      a       = (c == 0) ? 8'h21 : 8'h22;
      tick();
    end
    a_valid = 1'b0;
    #1;
    n_tests++; if (z_valid !== 1'b1 || cnt !== 3'd2) begin n_fail++; $display("FAIL rmid_pre got v=%b cnt=%0d want v=1 cnt=2", z_valid, cnt); end
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++; if (z_valid !== 1'b0 || cnt !== 3'd0 || z !== 8'h00) begin n_fail++; $display("FAIL rmid_async got v=%b cnt=%0d z=%h want v=0 cnt=0 z=00", z_valid, cnt, z); end
    n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got %b want 1", a_ready); end
    #1;
    reset_n = 1'b1;
    tick();
    z_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      a_valid = (c == 0);
      a       = 8'h11;
      #1;
      if (c == 0) begin
        n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_accept got %b want 1", a_ready); end
      end
      n_tests++; if (z_valid !== (c == 4)) begin n_fail++; $display("FAIL rmid_lat c=%0d got %b want %b", c, z_valid, (c == 4)); end
      if (c == 4) begin
        n_tests++; if (z !== 8'h11) begin n_fail++; $display("FAIL rmid_data got %h want 11", z); end
      end
      tick();
    end
    a_valid = 1'b0;
  endtask

  // D=0: pure combinational passthrough.
  task automatic test_passthru();
    logic ev, er;
    for (int i = 0; i < 20; i++) begin
      p_a_valid = 1'($urandom_range(1, 0));
      p_z_ready = 1'($urandom_range(1, 0));
      p_a       = 8'($urandom_range(255, 0));
      p_flush   = (i >= 16);
      #1;
      ev = p_a_valid & ~p_flush;
      er = p_z_ready & ~p_flush;
      n_tests++; if (p_z !== p_a) begin n_fail++; $display("FAIL pass_data i=%0d got %h want %h", i, p_z, p_a); end
      n_tests++; if (p_z_valid !== ev) begin n_fail++; $display("FAIL pass_valid i=%0d got %b want %b", i, p_z_valid, ev); end
      n_tests++; if (p_a_ready !== er) begin n_fail++; $display("FAIL pass_ready i=%0d got %b want %b", i, p_a_ready, er); end
      n_tests++; if (p_cnt !== 3'd0) begin n_fail++; $display("FAIL pass_cnt i=%0d got %0d want 0", i, p_cnt); end
      tick();
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    a_valid   = 1'b0;
    a         = '0;
    z_ready   = 1'b0;
    flush     = 1'b0;
    p_a_valid = 1'b0;
    p_a       = '0;
    p_z_ready = 1'b0;
    p_flush   = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_bubble();
    test_flush();
    test_reset_mid();
    test_passthru();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
